instr_mem_ctrl: RTL

INSTR_MEM_CTRL -- requirements
Module: instr_mem_ctrl

---
 rtl/arm_defs_pkg.sv | 22 ++
 rtl/imem_array.sv | 56 +++++
 rtl/instr_mem_ctrl.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/arm_defs_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : arm_defs_pkg                                                 |
// | Description : Shared definitions for the instruction-fetch memory path:    |
// |               fetch FSM state encoding, instruction word size in bytes,    |
// |               and the NOP value returned on a faulting fetch.              |
// | Ports       : none (package)                                               |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package arm_defs_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } fetch_state_e;

  localparam int unsigned c_word_bytes = 4;
  localparam logic [31:0] c_fault_nop  = 32'h0000_0000;

endpackage
`default_nettype wire

// File: rtl/imem_array.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : imem_array                                                   |
// | Description : DEPTH_WORDS x 32 instruction storage. One synchronous write  |
// |               port and one asynchronous read port; the controller samples |
// |               the read port on the same edge that accepts a request, so a |
// |               same-cycle write to that word is seen only by later reads.   |
// | Ports       : clk      - clock                                             |
// |               wr_en    - write enable                                      |
// |               wr_addr  - byte address of word to write (low bits ignored)  |
// |               wr_data  - word to write                                     |
// |               rd_addr  - byte address of word to read (low bits ignored)   |
// |               rd_data  - word read, zero when outside the array            |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module imem_array
  import arm_defs_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 48,
  parameter int unsigned ADDR_W      = 32
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [31:0]       wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [31:0]       rd_data
);

  localparam int unsigned c_idx_w   = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int unsigned c_sel_lsb = $clog2(c_word_bytes);

  logic [31:0]       mem_q [DEPTH_WORDS];
  logic [ADDR_W-1:0] w_wr_word;
  logic [ADDR_W-1:0] w_rd_word;
  logic              w_wr_hit;
  logic              w_rd_hit;

  // Full-width word index so that out-of-range addresses never alias
  // onto a valid entry through truncation.
  assign w_wr_word = wr_addr >> c_sel_lsb;
  assign w_rd_word = rd_addr >> c_sel_lsb;
  assign w_wr_hit  = (w_wr_word < ADDR_W'(DEPTH_WORDS));
  assign w_rd_hit  = (w_rd_word < ADDR_W'(DEPTH_WORDS));

  // Storage has no reset: contents survive rst and are defined only once written.
  always_ff @(posedge clk) begin
    if (wr_en && w_wr_hit) begin
      mem_q[w_wr_word[c_idx_w-1:0]] <= wr_data;
    end
  end

  assign rd_data = w_rd_hit ? mem_q[w_rd_word[c_idx_w-1:0]] : c_fault_nop;

endmodule
`default_nettype wire

// File: rtl/instr_mem_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : instr_mem_ctrl                                               |
// | Description : Instruction fetch controller with fixed LATENCY (1..4) from  |
// |               acceptance to response, valid/ready handshakes, fault check  |
// |               (misaligned or out of range), flush and program-load port.  |
// | Ports       : clk, rst (async, active-high)                                |
// |               req_valid/req_ready/req_addr     - fetch request            |
// |               resp_valid/resp_ready            - response handshake       |
// |               resp_instr/resp_fault            - response payload         |
// |               flush                            - drop in-flight fetch     |
// |               prog_we/prog_addr/prog_data      - program-load write       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module instr_mem_ctrl
  import arm_defs_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 48,
  parameter int unsigned LATENCY     = 1,
  parameter int unsigned ADDR_W      = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              req_ready,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_instr,
  output logic              resp_fault,
  input  logic              flush,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [31:0]       prog_data
);

  localparam int unsigned         c_cnt_w    = $clog2(LATENCY) + 1;
  localparam logic [c_cnt_w-1:0]  c_cnt_load = (LATENCY > 1) ? c_cnt_w'(LATENCY - 2) : '0;
  localparam int unsigned         c_sel_lsb  = $clog2(c_word_bytes);

  fetch_state_e       state_q, state_d;
  logic [c_cnt_w-1:0] cnt_q, cnt_d;
  logic [31:0]        instr_q, instr_d;
  logic               fault_q, fault_d;

  fetch_state_e       w_accept_state;
  logic               w_accept;
  logic               w_fault;
  logic [31:0]        w_rd_data;

  imem_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .ADDR_W      (ADDR_W)
  ) u_imem_array (
    .clk     (clk),
    .wr_en   (prog_we),
    .wr_addr (prog_addr),
    .wr_data (prog_data),
    .rd_addr (req_addr),
    .rd_data (w_rd_data)
  );

  // With single-cycle latency an accepted fetch goes straight to RESP;
  // otherwise it waits for the down-counter to expire.
  if (LATENCY == 1) begin : g_lat_one
    assign w_accept_state = ST_RESP;
  end else begin : g_lat_multi
    assign w_accept_state = ST_WAIT;
  end

  assign w_fault = (req_addr[c_sel_lsb-1:0] != '0) ||
                   (req_addr >= ADDR_W'(c_word_bytes * DEPTH_WORDS));

  always_comb begin
    req_ready = 1'b0;
    if (!flush) begin
      case (state_q)
        ST_IDLE: req_ready = 1'b1;
        ST_RESP: req_ready = resp_ready;
        default: req_ready = 1'b0;
      endcase
    end
  end

  assign w_accept = req_valid && req_ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    instr_d = instr_q;
    fault_d = fault_q;
    if (flush) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_WAIT: begin
          if (cnt_q == '0) begin
            state_d = ST_RESP;
          end else begin
            cnt_d = cnt_q - c_cnt_w'(1);
          end
        end
        ST_RESP: begin
          if (resp_ready) begin
            state_d = ST_IDLE;
          end
        end
        default: state_d = state_q;
      endcase
      // Acceptance overrides the RESP->IDLE move to give back-to-back fetches.
      // The array is sampled before this edge's write lands, so a colliding
      // program-load write is not visible to this fetch.
      if (w_accept) begin
        state_d = w_accept_state;
        cnt_d   = c_cnt_load;
        instr_d = w_fault ? c_fault_nop : w_rd_data;
        fault_d = w_fault;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      instr_q <= c_fault_nop;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      instr_q <= instr_d;
      fault_q <= fault_d;
    end
  end

  assign resp_valid = (state_q == ST_RESP);
  assign resp_instr = instr_q;
  assign resp_fault = fault_q;

endmodule
`default_nettype wire
